// File: rtl/z3_cfg_pkg.sv
// rtl/z3_cfg_pkg.sv - Zorro III autoconfig register map, type code and FSM state types
package z3_cfg_pkg;

    localparam logic [7:0] REG_ER_TYPE = 8'h00;
    localparam logic [7:0] REG_PROD    = 8'h04;
    localparam logic [7:0] REG_MFG     = 8'h10;
    localparam logic [7:0] REG_SERIAL  = 8'h18;
    localparam logic [7:0] REG_ROMVEC  = 8'h28;
    localparam logic [7:0] REG_LAST_RD = 8'h2E;
    localparam logic [7:0] REG_BASE    = 8'h44;
    localparam logic [7:0] REG_SHUTUP  = 8'h4C;

    localparam logic [1:0] Z3_TYPE = 2'b10;

    typedef enum logic [2:0] {
        BUS_IDLE,
        BUS_SETUP,
        BUS_STROBE,
        BUS_DATA,
        BUS_RELEASE
    } bus_state_e;

    typedef enum logic [2:0] {
        SC_IDLE,
        SC_READ,
        SC_DECIDE,
        SC_WRITE,
        SC_FIN
    } scan_state_e;

    // Even offset r sits on A8 = r[1], A7..A2 = r[7:2].
    function automatic logic [6:0] reg_to_addrl(input logic [7:0] r);
        return {r[1], r[7:2]};
    endfunction

endpackage

// File: rtl/z3_autoconfig_master_if.sv
// rtl/z3_autoconfig_master_if.sv - Zorro III slot bus signals between autoconfig master and card
interface z3_autoconfig_master_if;

    logic       Z_FCS_n;
    logic       DS3_n;
    logic       DOE;
    logic       READ;
    logic [1:0] FC;
    logic [7:0] addrh;
    logic [6:0] addrl;
    logic [7:0] DOUT;
    logic [3:0] DIN;
    logic       dtack;
    logic       BERR_n;
    logic       CFGIN_n;

    modport master (
        output Z_FCS_n, DS3_n, DOE, READ, FC, addrh, addrl, DOUT, CFGIN_n,
        input  DIN, dtack, BERR_n
    );

    modport slave (
        input  Z_FCS_n, DS3_n, DOE, READ, FC, addrh, addrl, DOUT, CFGIN_n,
        output DIN, dtack, BERR_n
    );

endinterface

// File: rtl/z3_bus_cycle.sv
// rtl/z3_bus_cycle.sv - single Zorro III access engine: setup, strobe, data wait, release
module z3_bus_cycle
    import z3_cfg_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic IORST_n,
    input  logic req,
    input  logic dtack,
    input  logic BERR_n,
    output logic z_fcs_n,
    output logic ds3_n,
    output logic doe,
    output logic data_ok,
    output logic ack,
    output logic fail
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    bus_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          timed_out;

    assign timed_out = (cnt_q == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge IORST_n) begin
        if (!IORST_n) begin
            state_q <= BUS_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == BUS_DATA) cnt_q <= cnt_q + 1'b1;
            else                     cnt_q <= '0;
        end
    end

    always_comb begin
        state_d = state_q;
        z_fcs_n = 1'b1;
        ds3_n   = 1'b1;
        doe     = 1'b0;
        data_ok = 1'b0;
        ack     = 1'b0;
        fail    = 1'b0;
        unique case (state_q)
            BUS_IDLE:   if (req) state_d = BUS_SETUP;
            BUS_SETUP:  state_d = BUS_STROBE;
            BUS_STROBE: begin
                z_fcs_n = 1'b0;
                state_d = BUS_DATA;
            end
            BUS_DATA: begin
                z_fcs_n = 1'b0;
                ds3_n   = 1'b0;
                doe     = 1'b1;
                // A bus error outranks an acknowledge seen in the same clock.
                if (!BERR_n || timed_out) begin
                    fail    = 1'b1;
                    state_d = BUS_IDLE;
                end else if (dtack) begin
                    data_ok = 1'b1;
                    state_d = BUS_RELEASE;
                end
            end
            BUS_RELEASE: begin
                ack     = 1'b1;
                state_d = req ? BUS_SETUP : BUS_IDLE;
            end
            default: state_d = BUS_IDLE;
        endcase
    end

endmodule

// File: rtl/z3_autoconfig_master.sv
// rtl/z3_autoconfig_master.sv - host-side Zorro III autoconfig scan, then base-address write or shut-up
module z3_autoconfig_master
    import z3_cfg_pkg::*;
#(
    parameter int         TIMEOUT = 255,
    parameter logic [1:0] FC_CODE = 2'b01
) (
    input  logic                    clk,
    input  logic                    IORST_n,
    input  logic                    start,
    input  logic [7:0]              base_addr,
    input  logic                    base_valid,
    z3_autoconfig_master_if.master  bus,
    output logic                    busy,
    output logic                    done,
    output logic                    found,
    output logic                    configured,
    output logic                    shutup,
    output logic [7:0]              er_type,
    output logic [7:0]              prod_id,
    output logic [15:0]             mfg_id,
    output logic [15:0]             romvec,
    output logic [31:0]             serial
);

    scan_state_e scan_q, scan_d;
    logic [7:0]  reg_q;
    logic [7:0]  dout_q;
    logic        rd_q;
    logic        cfgin_n_q;
    logic [95:0] nib_q;
    logic        req, scan_active;
    logic        data_ok, ack, fail;
    logic        z_fcs_n, ds3_n, doe;

    z3_bus_cycle #(.TIMEOUT(TIMEOUT)) u_cycle (
        .clk     (clk),
        .IORST_n (IORST_n),
        .req     (req),
        .dtack   (bus.dtack),
        .BERR_n  (bus.BERR_n),
        .z_fcs_n (z_fcs_n),
        .ds3_n   (ds3_n),
        .doe     (doe),
        .data_ok (data_ok),
        .ack     (ack),
        .fail    (fail)
    );

    assign bus.Z_FCS_n = z_fcs_n;
    assign bus.DS3_n   = ds3_n;
    assign bus.DOE     = doe;
    assign bus.READ    = rd_q;
    assign bus.FC      = FC_CODE;
    assign bus.addrh   = 8'hFF;
    assign bus.addrl   = reg_to_addrl(reg_q);
    assign bus.DOUT    = dout_q;
    assign bus.CFGIN_n = cfgin_n_q;

    // Nibble slot k (offset 2k) lives at nib_q[95-4k -: 4], so fields read MSB first.
    assign er_type = nib_q[95 - 2*int'(REG_ER_TYPE) -: 8];
    assign prod_id = nib_q[95 - 2*int'(REG_PROD)    -: 8];
    assign mfg_id  = nib_q[95 - 2*int'(REG_MFG)     -: 16];
    assign serial  = nib_q[95 - 2*int'(REG_SERIAL)  -: 32];
    assign romvec  = nib_q[95 - 2*int'(REG_ROMVEC)  -: 16];

    always_comb begin
        scan_d = scan_q;
        unique case (scan_q)
            SC_IDLE:   if (start) scan_d = SC_READ;
            SC_READ: begin
                if (fail)                              scan_d = SC_FIN;
                else if (ack && reg_q == REG_LAST_RD)  scan_d = SC_DECIDE;
            end
            SC_DECIDE: scan_d = SC_WRITE;
            SC_WRITE:  if (fail || ack) scan_d = SC_FIN;
            SC_FIN:    scan_d = SC_IDLE;
            default:   scan_d = SC_IDLE;
        endcase
        // Driving req from the next state lets accesses run back to back.
        req         = (scan_d == SC_READ) || (scan_d == SC_WRITE);
        scan_active = req || (scan_d == SC_DECIDE);
    end

    always_ff @(posedge clk or negedge IORST_n) begin
        if (!IORST_n) begin
            scan_q     <= SC_IDLE;
            reg_q      <= REG_ER_TYPE;
            dout_q     <= 8'h00;
            rd_q       <= 1'b1;
            cfgin_n_q  <= 1'b1;
            nib_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            configured <= 1'b0;
            shutup     <= 1'b0;
        end else begin
            scan_q    <= scan_d;
            busy      <= scan_active;
            cfgin_n_q <= !scan_active;
            done      <= (scan_d == SC_FIN);
            unique case (scan_q)
                SC_IDLE: if (start) begin
                    reg_q      <= REG_ER_TYPE;
                    dout_q     <= 8'h00;
                    rd_q       <= 1'b1;
                    nib_q      <= '0;
                    found      <= 1'b0;
                    configured <= 1'b0;
                    shutup     <= 1'b0;
                end
                SC_READ: begin
                    // Only the type nibbles at 0x00/0x02 are stored true; the rest are inverted.
                    if (data_ok)
                        nib_q[{5'd23 - reg_q[5:1], 2'b00} +: 4] <=
                            (reg_q < REG_PROD) ? bus.DIN : ~bus.DIN;
                    if (ack && reg_q != REG_LAST_RD) reg_q <= reg_q + 8'd2;
                    if (fail) found <= 1'b0;
                end
                SC_DECIDE: begin
                    found <= 1'b1;
                    rd_q  <= 1'b0;
                    if (er_type[7:6] == Z3_TYPE && base_valid) begin
                        reg_q  <= REG_BASE;
                        dout_q <= base_addr;
                    end else begin
                        reg_q  <= REG_SHUTUP;
                        dout_q <= 8'h00;
                    end
                end
                SC_WRITE: begin
                    if (fail) begin
                        found <= 1'b0;
                    end else if (ack) begin
                        if (reg_q == REG_BASE) configured <= 1'b1;
                        else                   shutup     <= 1'b1;
                    end
                end
                SC_FIN:  rd_q <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/z3_autoconfig_master.md
Name: z3_autoconfig_master

Overview:
- Host-side Zorro III autoconfig initiator for the bench/bring-up bus controller.
- Drives the slot's CFGIN_n, scans the 0xFF config space nibble by nibble, and assembles the board's ID fields.
- Then either writes the allocated base address to register 0x44, or shuts the board up via 0x4C.
- Counterpart to the card-side autoconfig responder on the same bus signals.

Parameters:
- TIMEOUT, 255: clocks to wait for dtack/BERR per access before the slot is declared empty.
- FC_CODE, 2'b01: function code driven during accesses; must have FC[1]!=FC[0].

Ports:
- clk  in  1  system clock
- IORST_n  in  1  asynchronous active-low reset
- start  in  1  one-clock pulse; begins a scan when idle
- base_addr  in  8  A31..A24 allocated by the host
- base_valid  in  1  host has space; if 0, the board is shut up
- Z_FCS_n  out  1  full cycle strobe, active low
- DS3_n  out  1  data strobe for D31..D24, active low
- DOE  out  1  data output enable
- READ  out  1  1=read, 0=write
- FC  out  2  function code
- addrh  out  8  A31..A24
- addrl  out  7  A8..A2
- DOUT  out  8  write data D31..D24
- DIN  in  4  read data D31..D28
- dtack  in  1  active-high acknowledge from the responder
- BERR_n  in  1  bus error, active low
- CFGIN_n  out  1  config-in to the target slot
- busy, done  out  1  status; done is a one-clock pulse
- found, configured, shutup  out  1  result flags
- er_type, prod_id  out  8  decoded fields
- mfg_id, romvec  out  16  decoded fields
- serial  out  32  decoded field

Behaviour:
- Reset:
  - All strobes are deasserted: Z_FCS_n=1, DS3_n=1, CFGIN_n=1.
  - DOE=0, READ=1, FC=FC_CODE, addrh=FF, addrl=0, DOUT=0.
  - All status flags and fields are 0.
  - Reset mid-access aborts immediately to IDLE with the bus released.
- Register offset r (even, 0x00..0x4E) maps to the bus as:
  - addrh=FF, addrl[8]=r[1], addrl[7:2]=r[7:2].
- FSM states: IDLE, SETUP, STROBE, DATA, RELEASE, DECIDE, FIN.
- IDLE:
  - start accepted only here; start while busy is ignored.
  - On start: CFGIN_n<=0, busy<=1, fields cleared, reg ptr<=0x00, READ<=1, go to SETUP.
- SETUP: 1 clk; address valid, Z_FCS_n=1.
- STROBE: 1 clk; Z_FCS_n=0.
- DATA:
  - Z_FCS_n=0, DS3_n=0, DOE=1; timeout counter runs.
  - Read: on dtack, latch DIN into nibble slot r/2 and go to RELEASE.
  - Write: DOUT is stable from SETUP; on dtack go to RELEASE.
  - BERR_n=0 or counter reaching TIMEOUT: found=0, go to FIN.
  - dtack and BERR_n=0 in the same clock: BERR wins.
- RELEASE:
  - 1 clk; Z_FCS_n=1, DS3_n=1, DOE=0.
  - Then the next read (r+=2, through 0x2E, 24 reads) or DECIDE after 0x2E.
  - After the write access, go to FIN.
- Nibble assembly:
  - Offsets 0x00 and 0x02 are taken raw; all others are inverted.
  - er_type={r00,r02}; prod_id=~{r04,r06}; mfg_id=~r10..r16; serial=~r18..r26; romvec=~r28..r2E (MSB first).
  - Offsets 0x08 and 0x0A are read but discarded.
- DECIDE:
  - found<=1.
  - If er_type[7:6]==2'b10 and base_valid: write base_addr to 0x44 with READ=0, and configured<=1 after dtack.
  - Otherwise: write 0x00 to 0x4C with READ=0, and shutup<=1 after dtack.
- FIN: CFGIN_n<=1, busy<=0, done pulse, then IDLE. The final RELEASE gives the card its Z_FCS_n rising edge, so its cfgout latches.
- Minimum access time is 5 clocks against a responder that registers dtack one clock after DS3_n falls.

Decomposition:
- Package z3_cfg_pkg holds:
  - register offsets (ER_TYPE=0x00, PROD=0x04, MFG=0x10, SERIAL=0x18, ROMVEC=0x28, LAST_RD=0x2E, BASE=0x44, SHUTUP=0x4C);
  - the Z3 type code 2'b10;
  - the FSM state enum.
- Sub-module z3_bus_cycle is the natural split: a single-access engine (SETUP..RELEASE, timeout, BERR) with req/ack to the scan FSM.

Test Plan:
- Responder with mfg 514, prod 84, serial 14, romvec 0x0200, base_valid=1, base_addr=0x40 -> er_type=0x90, prod_id=0x54, mfg_id=0x0202, serial=0x0000000E, romvec=0x0200, configured=1, the card answers at addrh=0x40, and its cfgout goes high.
- Same responder with base_valid=0 -> write to 0x4C, shutup=1, configured=0, and the card stops answering at FF.
- No responder (dtack never asserts) -> done after TIMEOUT+3 clocks, found=0, CFGIN_n back to 1, no write issued.
- BERR_n pulled low on the third read -> FIN, found=0, bus released within 1 clock.
- IORST_n asserted during DATA of read 10 -> all outputs at reset values asynchronously; a new start gives a full clean scan.
- start pulsed while busy -> ignored; exactly 25 Z_FCS_n falling edges per scan.
